// File: rtl/pi_address_sequencer.sv
// PI bus address sequencer: latches the 32-bit address from the AD bus via
// ALEH/ALEL, turns read/write strobes into memory requests, and advances the
// address by one halfword on every strobe release.
//
// Request handshake: o_request rises the cycle after a qualifying strobe
// falling edge, and o_request, o_write, o_address and o_wdata are then held
// until the cycle in which i_ack=1. o_request drops on the following cycle.
// If i_ack never comes, the request is dropped after TIMEOUT_CYCLES cycles
// and o_timeout pulses once.
module pi_address_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_n64_pi_aleh,
    input  logic        i_n64_pi_alel,
    input  logic        i_n64_pi_read_n,
    input  logic        i_n64_pi_write_n,
    input  logic [15:0] i_n64_pi_ad,
    output logic [15:0] o_n64_pi_ad,
    output logic        o_n64_pi_ad_oe,
    output logic [31:0] o_address,
    input  logic        i_address_valid,
    output logic        o_request,
    output logic        o_write,
    output logic [15:0] o_wdata,
    input  logic        i_ack,
    input  logic [15:0] i_rdata,
    output logic        o_timeout,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        ADDR_HIGH = 2'd0,
        ADDR_LOW  = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic          prev_read_n;
    logic          prev_write_n;
    logic [TW-1:0] timer;
    logic          pending_inc;

    logic read_fall;
    logic write_fall;
    logic strobe_rise;
    logic timeout_now;
    logic still_pending;

    // Strobe edges against last cycle's strobe levels; request status this cycle.
    always_comb begin
        read_fall     = prev_read_n & ~i_n64_pi_read_n;
        write_fall    = prev_write_n & ~i_n64_pi_write_n;
        strobe_rise   = (~prev_read_n & i_n64_pi_read_n) | (~prev_write_n & i_n64_pi_write_n);
        timeout_now   = o_request & ~i_ack & (timer == TIMER_LAST);
        still_pending = o_request & ~i_ack & ~timeout_now;
    end

    // AD is driven only while a valid read strobe is held low in ACTIVE.
    assign o_n64_pi_ad_oe = ~i_reset & (state == ACTIVE) & ~i_n64_pi_read_n & i_address_valid;
    assign o_state        = state;

    // Address latching, request issue/retire, timeout and address advance.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ADDR_HIGH;
            prev_read_n  <= 1'b1;
            prev_write_n <= 1'b1;
            timer        <= '0;
            pending_inc  <= 1'b0;
            o_address    <= 32'h0;
            o_n64_pi_ad  <= 16'h0;
            o_wdata      <= 16'h0;
            o_request    <= 1'b0;
            o_write      <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            prev_read_n  <= i_n64_pi_read_n;
            prev_write_n <= i_n64_pi_write_n;
            o_timeout    <= 1'b0;

            if (i_n64_pi_aleh && i_n64_pi_alel) begin
                // New address phase abandons whatever was in flight, silently.
                state                <= ADDR_HIGH;
                o_address[31:16]     <= i_n64_pi_ad;
                o_request            <= 1'b0;
                o_write              <= 1'b0;
                timer                <= '0;
                pending_inc          <= 1'b0;
            end else begin
                if (o_request) begin
                    if (i_ack) begin
                        o_request <= 1'b0;
                        timer     <= '0;
                        if (!o_write) begin
                            o_n64_pi_ad <= i_rdata;
                        end
                    end else if (timeout_now) begin
                        o_request <= 1'b0;
                        o_timeout <= 1'b1;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                case (state)
                    ADDR_HIGH, ADDR_LOW: begin
                        if (i_n64_pi_alel) begin
                            o_address[15:0] <= {i_n64_pi_ad[15:1], 1'b0};
                            state           <= ADDR_LOW;
                        end else if (state == ADDR_LOW) begin
                            state <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        // The address must not move under a live request, so a
                        // release during one is remembered and applied once it retires.
                        if (strobe_rise || pending_inc) begin
                            if (still_pending) begin
                                pending_inc <= 1'b1;
                            end else begin
                                o_address   <= o_address + 32'd2;
                                pending_inc <= 1'b0;
                            end
                        end
                        if (!o_request) begin
                            if (read_fall) begin
                                if (i_address_valid) begin
                                    o_request <= 1'b1;
                                    o_write   <= 1'b0;
                                end
                            end else if (write_fall) begin
                                o_wdata <= i_n64_pi_ad;
                                if (i_address_valid) begin
                                    o_request <= 1'b1;
                                    o_write   <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= ADDR_HIGH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pi_address_sequencer.sv
// Bench for pi_address_sequencer: directed scenarios plus randomized
// transactions checked against a transaction-level address/data model.
module tb_pi_address_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        aleh, alel, read_n, write_n;
    logic [15:0] ad_in;
    logic [15:0] ad_out;
    logic        ad_oe;
    logic [31:0] address;
    logic        address_valid;
    logic        request, write_dir;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        timeout;
    logic [1:0]  state;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_addr;
    logic [15:0] exp_q[$];

    pi_address_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_n64_pi_aleh(aleh), .i_n64_pi_alel(alel),
        .i_n64_pi_read_n(read_n), .i_n64_pi_write_n(write_n),
        .i_n64_pi_ad(ad_in), .o_n64_pi_ad(ad_out), .o_n64_pi_ad_oe(ad_oe),
        .o_address(address), .i_address_valid(address_valid),
        .o_request(request), .o_write(write_dir), .o_wdata(wdata),
        .i_ack(ack), .i_rdata(rdata), .o_timeout(timeout), .o_state(state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ale_addr(input logic [15:0] hi, input logic [15:0] lo);
        aleh = 1'b1; alel = 1'b1; ad_in = hi;
        tick();
        aleh = 1'b0; alel = 1'b1; ad_in = lo;
        tick();
        alel = 1'b0; ad_in = 16'h0;
        tick();
        exp_addr = {hi, lo[15:1], 1'b0};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({address, ad_out, wdata, ad_oe, request, write_dir, timeout, state} !== 70'h0) begin
            n_fail++;
            $display("FAIL reset: addr=%h ad=%h wdata=%h oe=%b req=%b wr=%b to=%b st=%0d want all zero",
                     address, ad_out, wdata, ad_oe, request, write_dir, timeout, state);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read();
        ale_addr(16'h1000, 16'h0003);
        address_valid = 1'b1;
        read_n = 1'b0;
        tick();
        n_cmp++;
        if ({address, request, write_dir, ad_oe} !== {32'h1000_0002, 3'b101}) begin
            n_fail++;
            $display("FAIL read_req: addr=%h req=%b wr=%b oe=%b want 10000002 1 0 1",
                     address, request, write_dir, ad_oe);
        end
        ack = 1'b1; rdata = 16'hBEEF;
        tick();
        ack = 1'b0;
        n_cmp++;
        if ({ad_out, request, ad_oe} !== {16'hBEEF, 2'b01}) begin
            n_fail++;
            $display("FAIL read_data: ad=%h req=%b oe=%b want beef 0 1", ad_out, request, ad_oe);
        end
        read_n = 1'b1;
        tick();
        n_cmp++;
        if (address !== 32'h1000_0004) begin
            n_fail++;
            $display("FAIL read_inc: addr=%h want 10000004", address);
        end
    endtask

    task automatic test_write();
        exp_addr = address;
        address_valid = 1'b1;
        write_n = 1'b0; ad_in = 16'h1234;
        tick();
        ad_in = 16'h0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({wdata, request, write_dir, address} !== {16'h1234, 2'b11, exp_addr}) begin
                n_fail++;
                $display("FAIL write_hold[%0d]: wdata=%h req=%b wr=%b addr=%h want 1234 1 1 %h",
                         i, wdata, request, write_dir, address, exp_addr);
            end
            tick();
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++;
        if (request !== 1'b0) begin
            n_fail++;
            $display("FAIL write_retire: req=%b want 0", request);
        end
        write_n = 1'b1;
        tick();
        n_cmp++;
        if (address !== exp_addr + 32'd2) begin
            n_fail++;
            $display("FAIL write_inc: addr=%h want %h", address, exp_addr + 32'd2);
        end
    endtask

    task automatic test_invalid();
        exp_addr = address;
        address_valid = 1'b0;
        read_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({request, ad_oe} !== 2'b00) begin
            n_fail++;
            $display("FAIL invalid_read: req=%b oe=%b want 0 0", request, ad_oe);
        end
        read_n = 1'b1;
        tick();
        n_cmp++;
        if (address !== exp_addr + 32'd2) begin
            n_fail++;
            $display("FAIL invalid_inc: addr=%h want %h", address, exp_addr + 32'd2);
        end
        address_valid = 1'b1;
    endtask

    task automatic test_wrap();
        ale_addr(16'hFFFF, 16'hFFFE);
        read_n = 1'b0;
        tick();
        ack = 1'b1; rdata = 16'h5A5A;
        tick();
        ack = 1'b0;
        read_n = 1'b1;
        tick();
        n_cmp++;
        if (address !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap: addr=%h want 00000000", address);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        ale_addr(16'h0040, 16'h0100);
        read_n = 1'b0;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        n_cmp++;
        if ({request, timeout} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_early: req=%b to=%b want 1 0", request, timeout);
        end
        tick();
        n_cmp++;
        if ({request, timeout} !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_fire: req=%b to=%b want 0 1", request, timeout);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (timeout) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL timeout_width: extra pulses=%0d want 0", pulses);
        end
        read_n = 1'b1;
        tick();
        n_cmp++;
        if (address !== exp_addr + 32'd2) begin
            n_fail++;
            $display("FAIL timeout_inc: addr=%h want %h", address, exp_addr + 32'd2);
        end
        exp_addr = exp_addr + 32'd2;
        // Acknowledge in the very last allowed cycle: ack wins, no timeout.
        read_n = 1'b0;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        ack = 1'b1; rdata = 16'hC0DE;
        tick();
        ack = 1'b0;
        n_cmp++;
        if ({request, timeout, ad_out} !== {2'b00, 16'hC0DE}) begin
            n_fail++;
            $display("FAIL ack_last: req=%b to=%b ad=%h want 0 0 c0de", request, timeout, ad_out);
        end
        tick();
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_last_after: to=%b want 0", timeout);
        end
        read_n = 1'b1;
        tick();
    endtask

    task automatic test_deferred();
        ale_addr(16'h0800, 16'h0010);
        read_n = 1'b0;
        tick();
        read_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({request, address} !== {1'b1, exp_addr}) begin
            n_fail++;
            $display("FAIL defer_hold: req=%b addr=%h want 1 %h", request, address, exp_addr);
        end
        ack = 1'b1; rdata = 16'h0F0F;
        tick();
        ack = 1'b0;
        n_cmp++;
        if ({request, address} !== {1'b0, exp_addr + 32'd2}) begin
            n_fail++;
            $display("FAIL defer_inc: req=%b addr=%h want 0 %h", request, address, exp_addr + 32'd2);
        end
    endtask

    task automatic test_abort();
        ale_addr(16'h1111, 16'h0020);
        read_n = 1'b0;
        tick();
        aleh = 1'b1; alel = 1'b1; ad_in = 16'h2222;
        tick();
        aleh = 1'b0; alel = 1'b0; read_n = 1'b1;
        n_cmp++;
        if ({request, timeout, state, address[31:16]} !== {2'b00, 2'd0, 16'h2222}) begin
            n_fail++;
            $display("FAIL ale_abort: req=%b to=%b st=%0d hi=%h want 0 0 0 2222",
                     request, timeout, state, address[31:16]);
        end
        tick();
        ale_addr(16'h3333, 16'h0040);
        write_n = 1'b0; ad_in = 16'hAAAA;
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({request, timeout, state, address} !== {2'b00, 2'd0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_abort: req=%b to=%b st=%0d addr=%h want 0 0 0 0",
                     request, timeout, state, address);
        end
        reset = 1'b0; write_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic        is_write, valid;
        logic [15:0] data;
        int          delay;
        ale_addr(16'($urandom), 16'($urandom));
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) ale_addr(16'($urandom), 16'($urandom));
            is_write = 1'($urandom_range(0, 1));
            valid    = ($urandom_range(0, 3) != 0);
            data     = 16'($urandom);
            delay    = $urandom_range(0, TO - 2);
            address_valid = valid;
            if (is_write) begin
                write_n = 1'b0; ad_in = data;
            end else begin
                read_n = 1'b0;
            end
            tick();
            ad_in = 16'h0;
            n_cmp++;
            if (request !== valid || (valid && (write_dir !== is_write || address !== exp_addr))
                || ad_oe !== (valid & ~is_write) || (is_write && wdata !== data)) begin
                n_fail++;
                $display("FAIL rand_req[%0d]: req=%b wr=%b addr=%h oe=%b wdata=%h want %b %b %h %b %h",
                         t, request, write_dir, address, ad_oe, wdata,
                         valid, is_write, exp_addr, valid & ~is_write, data);
            end
            if (valid) begin
                for (int i = 0; i < delay; i++) tick();
                ack = 1'b1;
                rdata = 16'($urandom);
                if (!is_write) exp_q.push_back(rdata);
                tick();
                ack = 1'b0;
                n_cmp++;
                if (request !== 1'b0 || timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_retire[%0d]: req=%b to=%b want 0 0", t, request, timeout);
                end
                if (!is_write) begin
                    n_cmp++;
                    if (ad_out !== exp_q[0]) begin
                        n_fail++;
                        $display("FAIL rand_rdata[%0d]: ad=%h want %h", t, ad_out, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            read_n = 1'b1; write_n = 1'b1;
            tick();
            exp_addr = exp_addr + 32'd2;
            n_cmp++;
            if (address !== exp_addr) begin
                n_fail++;
                $display("FAIL rand_inc[%0d]: addr=%h want %h", t, address, exp_addr);
            end
        end
        address_valid = 1'b1;
    endtask

    // Test sequence and final report
    initial begin
        reset = 1'b1; aleh = 1'b0; alel = 1'b0; read_n = 1'b1; write_n = 1'b1;
        ad_in = 16'h0; address_valid = 1'b1; ack = 1'b0; rdata = 16'h0;
        exp_addr = 32'h0;
        test_reset();
        test_read();
        test_write();
        test_invalid();
        test_wrap();
        test_timeout();
        test_deferred();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
